// File: rtl/tcam_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tcam_pkg                                               |
// | Description : Shared sizes, operation codes and FSM state encoding   |
// |               for the ternary match store access controller.         |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package tcam_pkg;

   localparam int DATA_W = 10;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   localparam logic [1:0] OP_SEARCH = 2'b00;
   localparam logic [1:0] OP_WRITE  = 2'b01;
   localparam logic [1:0] OP_INVAL  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/tcam_access_ctrl_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rr_arb2                                                |
// | Description : Two-request round-robin arbiter. On a tie the client   |
// |               that did not win last time is granted. Grants are      |
// |               combinational and only issued while enabled.           |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   // 1 means client 1 was granted most recently; starts at 1 so client 0
   // wins the first tie.
   logic last;

   // Pick the winner; grants are suppressed while reset is asserted.
   always_comb begin
      gnt = 2'b00;
      if (en && !reset) begin
         if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
         end else begin
            gnt = req;
         end
      end
   end

   // Remember which client received the most recent grant.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last <= 1'b1;
      end else if (|gnt) begin
         last <= gnt[1];
      end
   end

endmodule
`default_nettype wire

// File: rtl/tcam_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tcam_access_ctrl                                       |
// | Description : Owns a ternary match store and shares it between two   |
// |               clients. Writes/invalidates apply at the grant edge;   |
// |               searches scan one entry per cycle, lowest index first. |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tcam_access_ctrl
   import tcam_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              c0_req,
   input  logic [1:0]        c0_op,
   input  logic [ADDR_W-1:0] c0_addr,
   input  logic [DATA_W-1:0] c0_key,
   input  logic [DATA_W-1:0] c0_care,
   output logic              c0_gnt,
   output logic              c0_rsp_valid,
   input  logic              c1_req,
   input  logic [1:0]        c1_op,
   input  logic [ADDR_W-1:0] c1_addr,
   input  logic [DATA_W-1:0] c1_key,
   input  logic [DATA_W-1:0] c1_care,
   output logic              c1_gnt,
   output logic              c1_rsp_valid,
   output logic              rsp_hit,
   output logic [ADDR_W-1:0] rsp_idx,
   output logic              busy
);

   state_t              state;
   state_t              state_nxt;
   logic [1:0]          gnt;
   logic                grant;
   logic                sel;
   logic [1:0]          g_op;
   logic [ADDR_W-1:0]   g_addr;
   logic [DATA_W-1:0]   g_key;
   logic [DATA_W-1:0]   g_care;
   logic                g_search;
   logic                owner;
   logic [DATA_W-1:0]   key_q;
   logic [ADDR_W-1:0]   ptr;
   logic                match;
   logic                last_ptr;
   logic [DEPTH-1:0]    valid;
   logic [DATA_W-1:0]   value [DEPTH];
   logic [DATA_W-1:0]   care  [DEPTH];

   rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .en    (state == ST_IDLE),
      .req   ({c1_req, c0_req}),
      .gnt   (gnt)
   );

   // Fields of whichever client won this cycle; reserved op decodes as search.
   always_comb begin
      grant    = |gnt;
      sel      = gnt[1];
      g_op     = sel ? c1_op   : c0_op;
      g_addr   = sel ? c1_addr : c0_addr;
      g_key    = sel ? c1_key  : c0_key;
      g_care   = sel ? c1_care : c0_care;
      g_search = (g_op != OP_WRITE) && (g_op != OP_INVAL);
      match    = valid[ptr] && (((key_q ^ value[ptr]) & care[ptr]) == '0);
      last_ptr = (ptr == ADDR_W'(DEPTH - 1));
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and client-facing strobes.
   always_comb begin
      state_nxt    = state;
      c0_gnt       = gnt[0];
      c1_gnt       = gnt[1];
      c0_rsp_valid = (state == ST_RESP) && !owner;
      c1_rsp_valid = (state == ST_RESP) && owner;
      busy         = (state != ST_IDLE);
      case (state)
         ST_IDLE: if (grant) state_nxt = g_search ? ST_SCAN : ST_RESP;
         ST_SCAN: if (match || last_ptr) state_nxt = ST_RESP;
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Operation context, scan pointer and the held response fields.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner   <= 1'b0;
         key_q   <= '0;
         ptr     <= '0;
         rsp_hit <= 1'b0;
         rsp_idx <= '0;
      end else if (state == ST_IDLE) begin
         if (grant) begin
            owner <= sel;
            if (g_search) begin
               key_q <= g_key;
               ptr   <= '0;
            end else begin
               rsp_hit <= 1'b1;
               rsp_idx <= g_addr;
            end
         end
      end else if (state == ST_SCAN) begin
         if (match) begin
            rsp_hit <= 1'b1;
            rsp_idx <= ptr;
         end else if (last_ptr) begin
            rsp_hit <= 1'b0;
            rsp_idx <= '0;
         end else begin
            ptr <= ptr + ADDR_W'(1);
         end
      end
   end

   // Entry array: only modified at write/invalidate grant edges, so a scan
   // in progress always sees stable contents.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            value[i] <= '0;
            care[i]  <= '0;
         end
      end else if ((state == ST_IDLE) && grant) begin
         if (g_op == OP_WRITE) begin
            valid[g_addr] <= 1'b1;
            value[g_addr] <= g_key;
            care[g_addr]  <= g_care;
         end else if (g_op == OP_INVAL) begin
            valid[g_addr] <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tcam_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_tcam_access_ctrl                                    |
// | Description : Directed self-checking bench for tcam_access_ctrl.     |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_tcam_access_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       c0_req, c1_req;
   logic [1:0] c0_op, c1_op;
   logic [3:0] c0_addr, c1_addr;
   logic [9:0] c0_key, c1_key, c0_care, c1_care;
   logic       c0_gnt, c1_gnt, c0_rsp_valid, c1_rsp_valid;
   logic       rsp_hit;
   logic [3:0] rsp_idx;
   logic       busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   tcam_access_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .c0_req       (c0_req),
      .c0_op        (c0_op),
      .c0_addr      (c0_addr),
      .c0_key       (c0_key),
      .c0_care      (c0_care),
      .c0_gnt       (c0_gnt),
      .c0_rsp_valid (c0_rsp_valid),
      .c1_req       (c1_req),
      .c1_op        (c1_op),
      .c1_addr      (c1_addr),
      .c1_key       (c1_key),
      .c1_care      (c1_care),
      .c1_gnt       (c1_gnt),
      .c1_rsp_valid (c1_rsp_valid),
      .rsp_hit      (rsp_hit),
      .rsp_idx      (rsp_idx),
      .busy         (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Issue one operation from client c and check grant, latency and response.
   task automatic op(input string tag, input int c, input logic [1:0] o,
                     input logic [3:0] a, input logic [9:0] k, input logic [9:0] m,
                     input int exp_lat, input logic exp_hit, input logic [3:0] exp_idx);
      int   n;
      int   lat;
      logic g, rv, other;
      if (c == 0) begin
         c0_op = o; c0_addr = a; c0_key = k; c0_care = m; c0_req = 1'b1;
      end else begin
         c1_op = o; c1_addr = a; c1_key = k; c1_care = m; c1_req = 1'b1;
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
         g = (c == 0) ? c0_gnt : c1_gnt;
      end while (!g && n < 40);
      check({tag, "_gnt"}, {31'd0, g}, 32'd1);
      @(posedge clk);
      #1;
      c0_req = 1'b0;
      c1_req = 1'b0;
      n = 0;
      other = 1'b0;
      do begin
         @(negedge clk);
         n++;
         rv = (c == 0) ? c0_rsp_valid : c1_rsp_valid;
         if (((c == 0) ? c1_rsp_valid : c0_rsp_valid) === 1'b1) other = 1'b1;
      end while (!rv && n < 40);
      lat = rv ? n : -1;
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_hit"}, {31'd0, rsp_hit}, {31'd0, exp_hit});
      check({tag, "_idx"}, {28'd0, rsp_idx}, {28'd0, exp_idx});
      check({tag, "_other_rsp"}, {31'd0, other}, 32'd0);
   endtask

   initial begin
      int got[4];
      int k;
      int n;
      int seen;
      logic both;

      c0_req = 0; c0_op = 0; c0_addr = 0; c0_key = 0; c0_care = 0;
      c1_req = 0; c1_op = 0; c1_addr = 0; c1_key = 0; c1_care = 0;

      // Reset: grant must stay low even with a request pending.
      reset  = 1'b1;
      c0_req = 1'b1;
      #2;
      check("rst_gnt0", {31'd0, c0_gnt}, 32'd0);
      check("rst_rsp_hit", {31'd0, rsp_hit}, 32'd0);
      check("rst_rsp_idx", {28'd0, rsp_idx}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_rsp_valid", {30'd0, c1_rsp_valid, c0_rsp_valid}, 32'd0);
      c0_req = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;

      // Empty array: full scan miss.
      op("miss", 0, 2'b00, 4'd0, 10'h155, 10'h000, 17, 1'b0, 4'd0);

      // Write then masked search from the other client.
      op("wr3", 0, 2'b01, 4'd3, 10'h2A0, 10'h3F0, 1, 1'b1, 4'd3);
      op("c1_srch", 1, 2'b00, 4'd0, 10'h2A5, 10'h000, 5, 1'b1, 4'd3);

      // Lowest index wins; invalidate exposes the next one.
      op("wr2", 0, 2'b01, 4'd2, 10'h001, 10'h3FF, 1, 1'b1, 4'd2);
      op("wr9", 1, 2'b01, 4'd9, 10'h001, 10'h3FF, 1, 1'b1, 4'd9);
      op("srch_lo", 0, 2'b00, 4'd0, 10'h001, 10'h000, 4, 1'b1, 4'd2);
      op("inv2", 1, 2'b10, 4'd2, 10'h000, 10'h000, 1, 1'b1, 4'd2);
      op("srch_9", 0, 2'b00, 4'd0, 10'h001, 10'h000, 11, 1'b1, 4'd9);

      // Round robin with both clients requesting continuously.
      do_reset();
      c0_op = 2'b01; c0_addr = 4'd10; c0_key = 10'h3FF; c0_care = 10'h3FF;
      c1_op = 2'b01; c1_addr = 4'd11; c1_key = 10'h3FF; c1_care = 10'h3FF;
      c0_req = 1'b1;
      c1_req = 1'b1;
      got = '{-1, -1, -1, -1};
      k = 0;
      n = 0;
      both = 1'b0;
      while (k < 4 && n < 20) begin
         @(negedge clk);
         n++;
         if (c0_gnt && c1_gnt) both = 1'b1;
         if (c0_gnt) begin
            got[k] = 0; k++;
         end else if (c1_gnt) begin
            got[k] = 1; k++;
         end
      end
      @(posedge clk);
      #1;
      c0_req = 1'b0;
      c1_req = 1'b0;
      check("rr_g0", got[0], 0);
      check("rr_g1", got[1], 1);
      check("rr_g2", got[2], 0);
      check("rr_g3", got[3], 1);
      check("rr_both", {31'd0, both}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("rr_last_hit", {31'd0, rsp_hit}, 32'd1);
      check("rr_last_idx", {28'd0, rsp_idx}, 32'd11);

      // Reset in the 5th scan cycle aborts the search silently.
      c0_op = 2'b00; c0_key = 10'h000; c0_req = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!c0_gnt && n < 40);
      check("abort_gnt", {31'd0, c0_gnt}, 32'd1);
      @(posedge clk);
      #1 c0_req = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      check("abort_busy_scan", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      check("abort_rsp_valid", {30'd0, c1_rsp_valid, c0_rsp_valid}, 32'd0);
      check("abort_rsp_hit", {31'd0, rsp_hit}, 32'd0);
      check("abort_rsp_idx", {28'd0, rsp_idx}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (c0_rsp_valid || c1_rsp_valid) seen++;
      end
      check("abort_no_rsp", seen, 0);
      op("post_rst", 1, 2'b00, 4'd0, 10'h3FF, 10'h000, 17, 1'b0, 4'd0);

      // All-zero care mask at entry 0 matches any key.
      op("wr0", 0, 2'b01, 4'd0, 10'h123, 10'h000, 1, 1'b1, 4'd0);
      op("any_000", 1, 2'b00, 4'd0, 10'h000, 10'h000, 2, 1'b1, 4'd0);
      op("any_3ff", 0, 2'b00, 4'd0, 10'h3FF, 10'h000, 2, 1'b1, 4'd0);
      op("rsvd_op", 1, 2'b11, 4'd5, 10'h2AA, 10'h000, 2, 1'b1, 4'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
